div_unit: RTL and testbench

Iterative 32-bit radix-2 divider for MIPS `DIV`/`DIVU`, placed in the EXE stage alongside the ALU. It accepts one operand pair, runs 32 restoring-division iterations, and delivers quotient (LO) and remainder (HI) with a one-cycle done pulse. Its `div_busy` output drives the ID-stage hazard unit's `DIV_Busy` input, which stalls a following divide while this block is iterating.

---
 rtl/div_unit.sv | 95 +++++++++
 tb/tb_div_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider for MIPS DIV/DIVU.
// Produces the quotient (LO) and remainder (HI) 33 cycles after a start, with a one-cycle done pulse.
module div_unit (
   input  logic        clk,
   input  logic        resetn,
   input  logic        div_start,
   input  logic        div_signed,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        div_cancel,
   output logic        div_busy,
   output logic        div_done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state;
   logic [4:0]  count;
   logic [32:0] part_rem;
   logic [32:0] dsr_mag;
   logic [31:0] quo_shift;
   logic        q_neg;
   logic        r_neg;

   logic [32:0] shifted;
   logic [33:0] trial;
   logic [31:0] dvd_abs;
   logic [31:0] dsr_abs;

   // The dividend register doubles as the quotient: its MSB feeds the remainder, result bits enter at the LSB.
   always_comb begin
      shifted = {part_rem[31:0], quo_shift[31]};
      trial   = {1'b0, shifted} - {1'b0, dsr_mag};
      dvd_abs = (div_signed && dividend[31]) ? (32'd0 - dividend) : dividend;
      dsr_abs = (div_signed && divisor[31])  ? (32'd0 - divisor)  : divisor;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         count     <= 5'd0;
         part_rem  <= 33'd0;
         dsr_mag   <= 33'd0;
         quo_shift <= 32'd0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         div_busy  <= 1'b0;
         div_done  <= 1'b0;
         quotient  <= 32'd0;
         remainder <= 32'd0;
      end else begin
         div_done <= 1'b0;
         if (div_cancel) begin
            state    <= IDLE;
            div_busy <= 1'b0;
         end else if (state == RUN) begin
            if (trial[33]) begin
               part_rem  <= shifted;
               quo_shift <= {quo_shift[30:0], 1'b0};
            end else begin
               part_rem  <= trial[32:0];
               quo_shift <= {quo_shift[30:0], 1'b1};
            end
            count <= count + 5'd1;
            if (count == 5'd31) begin
               state    <= DONE;
               div_busy <= 1'b0;
            end
         end else begin
            // Results are published on the edge that leaves DONE, which may also accept the next start.
            if (state == DONE) begin
               quotient  <= q_neg ? (32'd0 - quo_shift) : quo_shift;
               remainder <= r_neg ? (32'd0 - part_rem[31:0]) : part_rem[31:0];
               div_done  <= 1'b1;
            end
            if (div_start) begin
               state     <= RUN;
               div_busy  <= 1'b1;
               count     <= 5'd0;
               part_rem  <= 33'd0;
               quo_shift <= dvd_abs;
               dsr_mag   <= {1'b0, dsr_abs};
               q_neg     <= div_signed & (dividend[31] ^ divisor[31]);
               r_neg     <= div_signed & dividend[31];
            end else begin
               state    <= IDLE;
               div_busy <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: a driver pushes reference results, a negedge monitor checks them,
// along with busy timing, result hold behaviour, cancel and asynchronous reset.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        div_start;
   logic        div_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        div_cancel;
   logic        div_busy;
   logic        div_done;
   logic [31:0] quotient;
   logic [31:0] remainder;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      int          start_edge;
   } exp_t;

   exp_t        exp_q[$];
   int          cyc = 0;
   int          compared = 0;
   int          mismatched = 0;
   int          busy_from = 1;
   int          busy_to = 0;
   logic [31:0] last_q = 32'd0;
   logic [31:0] last_r = 32'd0;
   bit          running = 1'b0;

   div_unit dut (
      .clk        (clk),
      .resetn     (resetn),
      .div_start  (div_start),
      .div_signed (div_signed),
      .dividend   (dividend),
      .divisor    (divisor),
      .div_cancel (div_cancel),
      .div_busy   (div_busy),
      .div_done   (div_done),
      .quotient   (quotient),
      .remainder  (remainder)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference divide from magnitudes with truncation toward zero; divisor 0 yields all-ones magnitude.
   function automatic void refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
      longint ma, mb, qm, rm;
      ma = longint'(a);
      mb = longint'(b);
      if (sgn && a[31]) ma = 64'h1_0000_0000 - ma;
      if (sgn && b[31]) mb = 64'h1_0000_0000 - mb;
      if (mb == 0) begin
         qm = 64'hFFFF_FFFF;
         rm = ma;
      end else begin
         qm = ma / mb;
         rm = ma % mb;
      end
      if (sgn && (a[31] ^ b[31])) qm = -qm;
      if (sgn && a[31]) rm = -rm;
      q = qm[31:0];
      r = rm[31:0];
   endfunction

   // Waits one negedge, drives a start pulse, and returns at the negedge after it was sampled.
   task automatic applyStimulus(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      @(negedge clk);
      div_start  = 1'b1;
      div_signed = sgn;
      dividend   = a;
      divisor    = b;
      refDiv(sgn, a, b, e.q, e.r);
      e.start_edge = cyc + 1;
      exp_q.push_back(e);
      busy_from = e.start_edge;
      busy_to   = e.start_edge + 31;
      @(negedge clk);
      div_start = 1'b0;
   endtask

   task automatic waitIdle();
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("result_timeout", {31'd0, ok}, 32'd1);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (running) begin
         checkOutput("busy", {31'd0, div_busy}, {31'd0, (cyc >= busy_from && cyc <= busy_to)});
         if (div_done) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_done", {31'd0, div_done}, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               checkOutput("quotient", quotient, e.q);
               checkOutput("remainder", remainder, e.r);
               checkOutput("latency", 32'(cyc - e.start_edge), 32'd33);
               last_q = e.q;
               last_r = e.r;
            end
         end else begin
            checkOutput("hold_quotient", quotient, last_q);
            checkOutput("hold_remainder", remainder, last_r);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      resetn     = 1'b0;
      div_start  = 1'b0;
      div_signed = 1'b0;
      dividend   = 32'd0;
      divisor    = 32'd0;
      div_cancel = 1'b0;
      running    = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", {31'd0, div_busy}, 32'd0);
      checkOutput("reset_done", {31'd0, div_done}, 32'd0);
      resetn = 1'b1;

      applyStimulus(1'b0, 32'd100, 32'd7);
      waitIdle();

      applyStimulus(1'b1, -32'sd7, 32'd2);
      waitIdle();
      applyStimulus(1'b1, 32'd7, -32'sd2);
      waitIdle();
      applyStimulus(1'b1, -32'sd7, -32'sd2);
      waitIdle();

      applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      waitIdle();
      applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1);
      waitIdle();
      applyStimulus(1'b0, 32'd5, 32'd0);
      waitIdle();
      applyStimulus(1'b1, -32'sd9, 32'd0);
      waitIdle();

      // Cancel sampled ten edges after the start; the pending result is dropped.
      applyStimulus(1'b0, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      div_cancel = 1'b1;
      busy_to = cyc;
      void'(exp_q.pop_back());
      @(negedge clk);
      div_cancel = 1'b0;
      repeat (40) @(negedge clk);

      @(negedge clk);
      div_start  = 1'b1;
      div_cancel = 1'b1;
      dividend   = 32'd50;
      divisor    = 32'd5;
      @(negedge clk);
      div_start  = 1'b0;
      div_cancel = 1'b0;
      repeat (40) @(negedge clk);

      // Second start lands in the DONE cycle of the first.
      applyStimulus(1'b0, 32'd12345, 32'd67);
      repeat (31) @(negedge clk);
      applyStimulus(1'b1, -32'sd1000, 32'd33);
      waitIdle();

      applyStimulus(1'b0, 32'd999, 32'd10);
      repeat (5) @(negedge clk);
      div_start = 1'b1;
      dividend  = 32'd1;
      divisor   = 32'd1;
      @(negedge clk);
      div_start = 1'b0;
      waitIdle();

      applyStimulus(1'b0, 32'd77777, 32'd13);
      repeat (19) @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("async_rst_busy", {31'd0, div_busy}, 32'd0);
      checkOutput("async_rst_done", {31'd0, div_done}, 32'd0);
      checkOutput("async_rst_quotient", quotient, 32'd0);
      checkOutput("async_rst_remainder", remainder, 32'd0);
      exp_q.delete();
      last_q    = 32'd0;
      last_r    = 32'd0;
      busy_from = 1;
      busy_to   = 0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      applyStimulus(1'b0, 32'd4096, 32'd3);
      waitIdle();

      for (int i = 0; i < 20; i++) begin
         bit          sgn;
         logic [31:0] a;
         logic [31:0] b;
         int          mode;
         sgn  = 1'($urandom_range(0, 1));
         a    = $urandom;
         mode = $urandom_range(0, 3);
         if (mode == 0)      b = 32'd0;
         else if (mode == 1) b = $urandom_range(1, 15);
         else if (mode == 2) b = -($urandom_range(1, 15));
         else                b = $urandom;
         applyStimulus(sgn, a, b);
         waitIdle();
      end

      checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
      running = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
